uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_pkg.sv | 17 +
 rtl/uart_rx_baud_tick.sv | 42 ++++
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: state encoding and parameter defaults.
package uart_rx_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_PARITY_ENABLED = 1;
    localparam int unsigned DEF_PARITY_ODD     = 0;
    localparam int unsigned DEF_CLOCKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Baud counter for the receiver: emits a sample strobe at mid start bit
// (half period) or at the end of each full bit period.
module uart_rx_baud_tick
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = DEF_CLOCKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic half_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_full;

    always_comb begin
        tick_c  = 1'b0;
        at_full = (cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));
        cnt_d   = cnt_q + CNT_W'(1);
        if (en_i) begin
            tick_c = half_i ? (cnt_q == CNT_W'(CLOCKS_PER_BIT / 2 - 1)) : at_full;
        end
        // Held at zero while idle; cleared on every strobe and never past the last count.
        if (!en_i || tick_c || at_full) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizes the serial line, deframes start/data/parity/stop
// and presents each frame in a single-entry valid/ready output slot.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PARITY_ENABLED   = DEF_PARITY_ENABLED,
    parameter int unsigned PARITY_ODD       = DEF_PARITY_ODD,
    parameter int unsigned CLOCKS_PER_BIT   = DEF_CLOCKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_serial,
    output logic [INPUT_DATA_WIDTH-1:0] rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        parity_error,
    output logic                        framing_error,
    output logic                        overrun_error,
    output logic                        busy
);

    localparam int unsigned W     = INPUT_DATA_WIDTH;
    localparam int unsigned BIT_W = $clog2(INPUT_DATA_WIDTH + 1);
    localparam logic        PAR_ODD = 1'(PARITY_ODD);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             line;
    rx_state_e        state_q,   state_d;
    logic [W-1:0]     shreg_q,   shreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             par_err_q, par_err_d;
    logic [W-1:0]     data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             perr_q,    perr_d;
    logic             ferr_q,    ferr_d;
    logic             ovr_q,     ovr_d;
    logic             busy_q;
    logic             slot_free;
    logic             baud_en;
    logic             baud_half;
    logic             tick_c;

    assign line      = sync_q[1];
    assign baud_en   = (state_q != ST_IDLE);
    assign baud_half = (state_q == ST_START);

    uart_rx_baud_tick #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .en_i   (baud_en),
        .half_i (baud_half),
        .tick_c (tick_c)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = 1'b0;
        slot_free = !valid_q || rx_ready;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (prev_q && !line) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    shreg_d = W'({line, shreg_q} >> 1);
                    if (bit_cnt_q == BIT_W'(W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_ENABLED != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) begin
                    par_err_d = (line != ((^shreg_q) ^ PAR_ODD));
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    state_d = ST_IDLE;
                    // A full slot that is not being drained this cycle loses the new frame.
                    if (slot_free) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        perr_d  = par_err_q;
                        ferr_d  = !line;
                    end else begin
                        ovr_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_serial};
            prev_q    <= line;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign overrun_error = ovr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks/bit, 8 data bits, even parity.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         hi_cnt   = 0;
    int         ovr_cnt  = 0;
    int         ovr_cyc  = 0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    logic       prev_v   = 1'b0;

    uart_rx_ctrl #(
        .INPUT_DATA_WIDTH (8),
        .PARITY_ENABLED   (1),
        .PARITY_ODD       (0),
        .CLOCKS_PER_BIT   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_serial     (rx_serial),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe outputs just after each active edge; cyc equals the edge number.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            hi_cnt++;
            if (!prev_v) begin
                rise_cnt++;
                rise_cyc = cyc;
                cap_data = rx_data;
                cap_perr = parity_error;
                cap_ferr = framing_error;
            end
        end
        prev_v = (rx_valid === 1'b1);
        if (overrun_error === 1'b1) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts the falling edge at the current negedge; leaves line at idle_lvl.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic idle_lvl);
        rx_serial = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            step(16);
        end
        rx_serial = p;
        step(16);
        rx_serial = s;
        step(16);
        rx_serial = idle_lvl;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_serial = 1'b1; rx_ready = 1'b0;
        step(3);
        vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h want 00", rx_data); end
        vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        vec_cnt++; if ({parity_error, framing_error, overrun_error} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b want 000", {parity_error, framing_error, overrun_error}); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        step(4);
    endtask

    task automatic test_basic();
        int r0, h0, e0;
        rx_ready = 1'b1;
        r0 = rise_cnt; h0 = hi_cnt; e0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        step(4);
        vec_cnt++; if (rise_cnt - r0 !== 1) begin err_cnt++; $display("FAIL basic_count: got %0d want 1", rise_cnt - r0); end
        vec_cnt++; if (rise_cyc - e0 !== 171) begin err_cnt++; $display("FAIL basic_latency: got %0d want 171", rise_cyc - e0); end
        vec_cnt++; if (cap_data !== 8'hA5) begin err_cnt++; $display("FAIL basic_data: got %h want a5", cap_data); end
        vec_cnt++; if ({cap_perr, cap_ferr} !== 2'b00) begin err_cnt++; $display("FAIL basic_flags: got %b want 00", {cap_perr, cap_ferr}); end
        vec_cnt++; if (hi_cnt - h0 !== 1) begin err_cnt++; $display("FAIL basic_valid_width: got %0d want 1", hi_cnt - h0); end
        vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_valid_clear: got %b want 0", rx_valid); end
    endtask

    task automatic test_parity_error();
        int r0;
        r0 = rise_cnt;
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        step(4);
        vec_cnt++; if (rise_cnt - r0 !== 1) begin err_cnt++; $display("FAIL par_count: got %0d want 1", rise_cnt - r0); end
        vec_cnt++; if (cap_data !== 8'h01) begin err_cnt++; $display("FAIL par_data: got %h want 01", cap_data); end
        vec_cnt++; if ({cap_perr, cap_ferr} !== 2'b10) begin err_cnt++; $display("FAIL par_flags: got %b want 10", {cap_perr, cap_ferr}); end
        vec_cnt++; if ({parity_error, framing_error} !== 2'b00) begin err_cnt++; $display("FAIL par_flag_clear: got %b want 00", {parity_error, framing_error}); end
    endtask

    task automatic test_framing();
        int r0;
        r0 = rise_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL frm_busy_after_stop: got %b want 0", busy); end
        step(40 * 16);
        vec_cnt++; if (cap_data !== 8'h5A) begin err_cnt++; $display("FAIL frm_data: got %h want 5a", cap_data); end
        vec_cnt++; if ({cap_perr, cap_ferr} !== 2'b01) begin err_cnt++; $display("FAIL frm_flags: got %b want 01", {cap_perr, cap_ferr}); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL frm_busy_low_line: got %b want 0", busy); end
        rx_serial = 1'b1;
        step(20);
        vec_cnt++; if (rise_cnt - r0 !== 1) begin err_cnt++; $display("FAIL frm_count: got %0d want 1", rise_cnt - r0); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL frm_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_cnt;
        rx_serial = 1'b0;
        step(2);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy_e2: got %b want 0", busy); end
        step(1);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy_e3: got %b want 1", busy); end
        step(1);
        rx_serial = 1'b1;
        step(6);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy_e10: got %b want 1", busy); end
        step(1);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy_e11: got %b want 0", busy); end
        step(30);
        vec_cnt++; if (rise_cnt - r0 !== 0) begin err_cnt++; $display("FAIL glitch_no_valid: got %0d want 0", rise_cnt - r0); end
    endtask

    task automatic test_overrun();
        int r0, o0, e2;
        rx_ready = 1'b0;
        r0 = rise_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        step(4);
        vec_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin err_cnt++; $display("FAIL ovr_first: got valid=%b data=%h want valid=1 data=11", rx_valid, rx_data); end
        e2 = cyc;
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        step(4);
        vec_cnt++; if (ovr_cnt - o0 !== 1) begin err_cnt++; $display("FAIL ovr_pulse_width: got %0d want 1", ovr_cnt - o0); end
        vec_cnt++; if (ovr_cyc - e2 !== 171) begin err_cnt++; $display("FAIL ovr_pulse_time: got %0d want 171", ovr_cyc - e2); end
        vec_cnt++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_kept: got valid=%b data=%h want valid=1 data=11", rx_valid, rx_data); end
        vec_cnt++; if (rise_cnt - r0 !== 1) begin err_cnt++; $display("FAIL ovr_rises: got %0d want 1", rise_cnt - r0); end
        o0 = ovr_cnt;
        fork
            send_frame(8'h22, 1'b0, 1'b1, 1'b1);
            begin
                step(170);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        step(4);
        vec_cnt++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_replace: got valid=%b data=%h want valid=1 data=22", rx_valid, rx_data); end
        vec_cnt++; if (ovr_cnt - o0 !== 0) begin err_cnt++; $display("FAIL ovr_none: got %0d want 0", ovr_cnt - o0); end
        rx_ready = 1'b1;
        step(1);
        vec_cnt++; if (rx_valid !== 1'b0 || rx_data !== 8'h22) begin err_cnt++; $display("FAIL ovr_drain: got valid=%b data=%h want valid=0 data=22", rx_valid, rx_data); end
    endtask

    task automatic test_reset_mid();
        int r0, e0;
        logic [7:0] d;
        d = 8'h3C;
        r0 = rise_cnt;
        rx_serial = 1'b0;
        step(16);
        for (int i = 0; i < 3; i++) begin
            rx_serial = d[i];
            step(16);
        end
        rx_serial = d[3];
        step(8);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        step(1);
        vec_cnt++; if ({rx_data, rx_valid, parity_error, framing_error, overrun_error, busy} !== 13'h0) begin err_cnt++; $display("FAIL rst_mid_outputs: got %h want 0000", {rx_data, rx_valid, parity_error, framing_error, overrun_error, busy}); end
        reset = 1'b0;
        rx_serial = 1'b1;
        step(20);
        vec_cnt++; if (rise_cnt - r0 !== 0) begin err_cnt++; $display("FAIL rst_mid_discard: got %0d want 0", rise_cnt - r0); end
        e0 = cyc;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        step(4);
        vec_cnt++; if (rise_cnt - r0 !== 1 || rise_cyc - e0 !== 171) begin err_cnt++; $display("FAIL rst_mid_next_frame: got count=%0d latency=%0d want 1/171", rise_cnt - r0, rise_cyc - e0); end
        vec_cnt++; if (cap_data !== 8'h3C || {cap_perr, cap_ferr} !== 2'b00) begin err_cnt++; $display("FAIL rst_mid_next_data: got %h flags=%b want 3c flags=00", cap_data, {cap_perr, cap_ferr}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_error();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
